// File: rtl/uart_cmd_ctrl_if.sv
// Bus bundle between the UART command sequencer and its neighbours:
// received-word strobe, framebuffer write port, config write port and status.
interface uart_cmd_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic [31:0]       rx_data;
    logic              rx_flag;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cfg_we;
    logic [3:0]        cfg_sel;
    logic [31:0]       cfg_data;
    logic              busy;
    logic              done;
    logic [1:0]        err;

    // Sequencer side
    modport master (
        input  rx_data, rx_flag, wr_ready,
        output wr_en, wr_addr, wr_data, cfg_we, cfg_sel, cfg_data, busy, done, err
    );

    // Receiver / framebuffer / config side
    modport slave (
        output rx_data, rx_flag, wr_ready,
        input  wr_en, wr_addr, wr_data, cfg_we, cfg_sel, cfg_data, busy, done, err
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: decodes 32-bit header words and drives framebuffer
// write bursts, zero-fill bursts and config-register writes. A 1-entry skid
// buffer absorbs words that arrive while the sequencer cannot take them.
module uart_cmd_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic            clk,
    input  logic            rst_n,   // active-high synchronous reset
    uart_cmd_ctrl_if.master bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] OP_WRITE = 8'hA5;
    localparam logic [7:0] OP_FILL  = 8'h3C;
    localparam logic [7:0] OP_CFG   = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE, S_PAYLOAD, S_WRWAIT, S_FILLING, S_CFGVAL, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              skid_full_q, skid_full_d;
    logic [31:0]       skid_data_q, skid_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        rem_q, rem_d;
    logic [31:0]       data_q, data_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [1:0]        err_q, err_d;
    logic              cfg_we_q, cfg_we_d;
    logic [3:0]        cfg_sel_q, cfg_sel_d;
    logic [31:0]       cfg_data_q, cfg_data_d;

    logic              avail;
    logic              take;
    logic [31:0]       word;

    // Next-state, datapath and skid-buffer logic
    always_comb begin
        state_d     = state_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        data_d      = data_q;
        timer_d     = timer_q;
        err_d       = err_q;
        cfg_we_d    = 1'b0;
        cfg_sel_d   = cfg_sel_q;
        cfg_data_d  = cfg_data_q;
        take        = 1'b0;

        // Oldest word first: the buffered one, else the word on the wire this cycle
        avail = skid_full_q | bus.rx_flag;
        word  = skid_full_q ? skid_data_q : bus.rx_data;

        case (state_q)
            S_IDLE: begin
                if (avail) begin
                    take   = 1'b1;
                    addr_d = word[8 +: ADDR_W];
                    // len 0 encodes 256
                    rem_d  = {(word[7:0] == 8'd0), word[7:0]};
                    case (word[31:24])
                        OP_WRITE: begin
                            state_d = S_PAYLOAD;
                            err_d   = 2'd0;
                        end
                        OP_FILL: begin
                            state_d = S_FILLING;
                            err_d   = 2'd0;
                            data_d  = 32'd0;
                        end
                        OP_CFG: begin
                            state_d = S_CFGVAL;
                            err_d   = 2'd0;
                        end
                        default: err_d = 2'd1;
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (avail) begin
                    take    = 1'b1;
                    data_d  = word;
                    state_d = S_WRWAIT;
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 2'd2;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WRWAIT, S_FILLING: begin
                if (bus.wr_ready) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == 9'd1) begin
                        state_d = S_DONE;
                    end else if (state_q == S_WRWAIT) begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_CFGVAL: begin
                if (avail) begin
                    take       = 1'b1;
                    cfg_we_d   = 1'b1;
                    cfg_sel_d  = addr_q[3:0];
                    cfg_data_d = word;
                    state_d    = S_DONE;
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 2'd2;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Idle timer restarts whenever a word is consumed or a state is entered
        if (take || (state_d != state_q)) begin
            timer_d = '0;
        end

        // Skid buffer: refill behind a drained entry, or capture / drop a new word
        if (take) begin
            if (skid_full_q) begin
                skid_full_d = bus.rx_flag;
                if (bus.rx_flag) begin
                    skid_data_d = bus.rx_data;
                end
            end
        end else if (bus.rx_flag) begin
            if (!skid_full_q) begin
                skid_full_d = 1'b1;
                skid_data_d = bus.rx_data;
            end else begin
                err_d = 2'd3;
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            timer_q     <= '0;
            err_q       <= 2'd0;
            cfg_we_q    <= 1'b0;
            cfg_sel_q   <= '0;
            cfg_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            cfg_we_q    <= cfg_we_d;
            cfg_sel_q   <= cfg_sel_d;
            cfg_data_q  <= cfg_data_d;
        end
    end

    assign bus.wr_en    = (state_q == S_WRWAIT) || (state_q == S_FILLING);
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = data_q;
    assign bus.cfg_we   = cfg_we_q;
    assign bus.cfg_sel  = cfg_sel_q;
    assign bus.cfg_data = cfg_data_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed testbench for uart_cmd_ctrl.
module tb_uart_cmd_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    uart_cmd_ctrl_if #(.ADDR_W(16)) bus ();

    uart_cmd_ctrl #(.ADDR_W(16), .TIMEOUT_CYC(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Transaction log, sampled mid-cycle: an active handshake here is accepted at the next edge
    logic [15:0] wa_log [0:1023];
    logic [31:0] wd_log [0:1023];
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          cfg_cnt = 0;
    int          overlap_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            if (bus.wr_en && bus.wr_ready) begin
                if (wr_cnt < 1024) begin
                    wa_log[wr_cnt] = bus.wr_addr;
                    wd_log[wr_cnt] = bus.wr_data;
                end
                wr_cnt = wr_cnt + 1;
            end
            if (bus.done)               done_cnt = done_cnt + 1;
            if (bus.cfg_we)             cfg_cnt = cfg_cnt + 1;
            if (bus.cfg_we && bus.wr_en) overlap_cnt = overlap_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bus.rx_data = w;
        bus.rx_flag = 1'b1;
        tick();
        bus.rx_flag = 1'b0;
        bus.rx_data = 32'd0;
    endtask

    // Wait (bounded) for the done pulse, then step past it
    task automatic wait_done(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!bus.done && n < max_cyc) begin
            tick();
            n++;
        end
        n_checks++;
        if (!bus.done) begin
            n_fail++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", name, max_cyc);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.wr_en, bus.cfg_we, bus.busy, bus.done, bus.err} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got wr_en/cfg_we/busy/done/err=%b expected 000000",
                     {bus.wr_en, bus.cfg_we, bus.busy, bus.done, bus.err});
        end
        n_checks++;
        if ({bus.wr_addr, bus.wr_data, bus.cfg_sel, bus.cfg_data} !== 84'd0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h data=%h sel=%h cdata=%h expected all 0",
                     bus.wr_addr, bus.wr_data, bus.cfg_sel, bus.cfg_data);
        end
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int base, d0;
        base = wr_cnt;
        d0 = done_cnt;
        bus.wr_ready = 1'b1;
        send_word(32'hA5001002);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL write_hdr: got busy=%b wr_en=%b expected busy=1 wr_en=0", bus.busy, bus.wr_en);
        end
        send_word(32'h11111111);
        n_checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 16'h0010 || bus.wr_data !== 32'h11111111) begin
            n_fail++;
            $display("FAIL write_first: got en=%b addr=%h data=%h expected 1 0010 11111111",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        send_word(32'h22222222);
        wait_done("write", 20);
        n_checks++;
        if (bus.done !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_after: got done=%b wr_en=%b busy=%b expected 0 0 0",
                     bus.done, bus.wr_en, bus.busy);
        end
        n_checks++;
        if (wr_cnt - base !== 2) begin
            n_fail++;
            $display("FAIL write_count: got %0d expected 2", wr_cnt - base);
        end else begin
            n_checks++;
            if (wa_log[base] !== 16'h0010 || wd_log[base] !== 32'h11111111 ||
                wa_log[base+1] !== 16'h0011 || wd_log[base+1] !== 32'h22222222) begin
                n_fail++;
                $display("FAIL write_log: got %h:%h %h:%h expected 0010:11111111 0011:22222222",
                         wa_log[base], wd_log[base], wa_log[base+1], wd_log[base+1]);
            end
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL write_done_pulses: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int base;
        base = wr_cnt;
        bus.wr_ready = 1'b0;
        send_word(32'hA5001002);
        send_word(32'h11111111);
        send_word(32'h22222222);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== 16'h0010 || bus.wr_data !== 32'h11111111) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got en=%b addr=%h data=%h expected 1 0010 11111111",
                         i, bus.wr_en, bus.wr_addr, bus.wr_data);
            end
            tick();
        end
        bus.wr_ready = 1'b1;
        wait_done("bp", 20);
        n_checks++;
        if (wr_cnt - base !== 2) begin
            n_fail++;
            $display("FAIL bp_count: got %0d expected 2", wr_cnt - base);
        end else begin
            n_checks++;
            if (wa_log[base+1] !== 16'h0011 || wd_log[base+1] !== 32'h22222222) begin
                n_fail++;
                $display("FAIL bp_second: got %h:%h expected 0011:22222222", wa_log[base+1], wd_log[base+1]);
            end
        end
        n_checks++;
        if (bus.err !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_err: got %0d expected 0", bus.err);
        end
    endtask

    task automatic test_fill();
        int base, d0, bad;
        base = wr_cnt;
        d0 = done_cnt;
        bus.wr_ready = 1'b1;
        send_word(32'h3CFFFF00);
        n_checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 16'hFFFF || bus.wr_data !== 32'd0) begin
            n_fail++;
            $display("FAIL fill_first: got en=%b addr=%h data=%h expected 1 ffff 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        wait_done("fill", 300);
        n_checks++;
        if (wr_cnt - base !== 256) begin
            n_fail++;
            $display("FAIL fill_count: got %0d expected 256", wr_cnt - base);
        end else begin
            n_checks++;
            if (wa_log[base] !== 16'hFFFF || wa_log[base+1] !== 16'h0000 || wa_log[base+255] !== 16'h00FE) begin
                n_fail++;
                $display("FAIL fill_addr: got %h %h .. %h expected ffff 0000 .. 00fe",
                         wa_log[base], wa_log[base+1], wa_log[base+255]);
            end
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                if (wd_log[base+i] !== 32'd0) bad++;
            end
            n_checks++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL fill_data: got %0d nonzero words expected 0", bad);
            end
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL fill_done_pulses: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_cfg();
        int wbase, cbase;
        wbase = wr_cnt;
        cbase = cfg_cnt;
        send_word(32'h5A000300);
        send_word(32'hDEADBEEF);
        n_checks++;
        if (bus.cfg_we !== 1'b1 || bus.cfg_sel !== 4'd3 || bus.cfg_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL cfg_write: got we=%b sel=%0d data=%h expected 1 3 deadbeef",
                     bus.cfg_we, bus.cfg_sel, bus.cfg_data);
        end
        tick();
        tick();
        n_checks++;
        if (bus.cfg_we !== 1'b0 || cfg_cnt - cbase !== 1) begin
            n_fail++;
            $display("FAIL cfg_single: got we=%b pulses=%0d expected 0 1", bus.cfg_we, cfg_cnt - cbase);
        end
        n_checks++;
        if (overlap_cnt !== 0 || wr_cnt !== wbase) begin
            n_fail++;
            $display("FAIL cfg_no_wr: got overlaps=%0d writes=%0d expected 0 0", overlap_cnt, wr_cnt - wbase);
        end
    endtask

    task automatic test_errors();
        int base, d0;
        send_word(32'h77001201);
        n_checks++;
        if (bus.err !== 2'd1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_badop: got err=%0d busy=%b expected 1 0", bus.err, bus.busy);
        end
        base = wr_cnt;
        d0 = done_cnt;
        bus.wr_ready = 1'b1;
        send_word(32'hA5002003);
        n_checks++;
        if (bus.err !== 2'd0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: got err=%0d busy=%b expected 0 1", bus.err, bus.busy);
        end
        send_word(32'hAAAA5555);
        tick();
        repeat (19) tick();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.err !== 2'd0) begin
            n_fail++;
            $display("FAIL err_early_timeout: got busy=%b err=%0d expected 1 0", bus.busy, bus.err);
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.err !== 2'd2) begin
            n_fail++;
            $display("FAIL err_timeout: got busy=%b err=%0d expected 0 2", bus.busy, bus.err);
        end
        n_checks++;
        if (wr_cnt - base !== 1 || done_cnt !== d0) begin
            n_fail++;
            $display("FAIL err_timeout_side: got writes=%0d dones=%0d expected 1 0", wr_cnt - base, done_cnt - d0);
        end
    endtask

    task automatic test_overflow_reset();
        int base, d0;
        base = wr_cnt;
        d0 = done_cnt;
        bus.wr_ready = 1'b0;
        send_word(32'hA5004003);
        send_word(32'hBBBB0001);
        send_word(32'hBBBB0002);
        send_word(32'hBBBB0003);
        n_checks++;
        if (bus.err !== 2'd3 || bus.busy !== 1'b1 || bus.wr_data !== 32'hBBBB0001) begin
            n_fail++;
            $display("FAIL ovf_err: got err=%0d busy=%b data=%h expected 3 1 bbbb0001",
                     bus.err, bus.busy, bus.wr_data);
        end
        bus.wr_ready = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (wr_cnt - base !== 2) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d expected 2", wr_cnt - base);
        end else begin
            n_checks++;
            if (wd_log[base] !== 32'hBBBB0001 || wd_log[base+1] !== 32'hBBBB0002 || wa_log[base+1] !== 16'h0041) begin
                n_fail++;
                $display("FAIL ovf_log: got %h %h@%h expected bbbb0001 bbbb0002@0041",
                         wd_log[base], wd_log[base+1], wa_log[base+1]);
            end
        end
        n_checks++;
        if (bus.err !== 2'd3 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got err=%0d busy=%b expected 3 1", bus.err, bus.busy);
        end
        bus.wr_ready = 1'b0;
        send_word(32'hBBBB0004);
        n_checks++;
        if (bus.wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_third: got wr_en=%b expected 1", bus.wr_en);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({bus.wr_en, bus.cfg_we, bus.busy, bus.done, bus.err, bus.wr_addr,
             bus.wr_data, bus.cfg_sel, bus.cfg_data} !== 90'd0) begin
            n_fail++;
            $display("FAIL midreset: got en=%b busy=%b done=%b err=%0d addr=%h data=%h expected all 0",
                     bus.wr_en, bus.busy, bus.done, bus.err, bus.wr_addr, bus.wr_data);
        end
        rst_n = 1'b0;
        bus.wr_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.busy !== 1'b0 || done_cnt !== d0) begin
            n_fail++;
            $display("FAIL midreset_after: got busy=%b dones=%0d expected 0 0", bus.busy, done_cnt - d0);
        end
    endtask

    initial begin
        bus.rx_data  = 32'd0;
        bus.rx_flag  = 1'b0;
        bus.wr_ready = 1'b0;
        test_reset();
        test_write();
        test_backpressure();
        test_fill();
        test_cfg();
        test_errors();
        test_overflow_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "simulation time limit reached");
    end
endmodule
